// File: rtl/int_controller.sv
// Interrupt controller: synchronises IRQ lines, latches and masks pending requests, and hands
// the lowest-index active line to the sequencer. Optional level-sensitive mode: INT_LEVEL_SENSE_EN.
module int_controller #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] maskIn,
    input  logic               MASKld,
    input  logic               MASKclr,
    input  logic               INTld,
    input  logic               INTclr,
    input  logic               intDisable,
    input  logic               clrPend,
    input  logic               intReturn,
    output logic               intPending,
    output logic [VEC_W-1:0]   intVector,
    output logic               inService,
    output logic [NUM_IRQ-1:0] pendStatus
);

    if (NUM_IRQ < 2 || NUM_IRQ > 16 || (2 ** VEC_W) < NUM_IRQ) begin : g_bad_params
        $error("int_controller: NUM_IRQ must be 2..16 and fit in VEC_W bits");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, SERVICE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] s0_q, s1_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               glob_en_q, glob_en_d;
    logic [VEC_W-1:0]   vector_q, vector_d;

    logic [NUM_IRQ-1:0] active_s;
    logic [NUM_IRQ-1:0] win_onehot_s;
    logic [VEC_W-1:0]   win_idx_s;
    logic               int_pending_s;
    logic               ack_s;

`ifndef INT_LEVEL_SENSE_EN
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise_s;
    assign rise_s = s1_q & ~prev_q;
`endif

    assign active_s      = pending_q & mask_q;
    assign int_pending_s = glob_en_q & (|active_s) & (state_q == IDLE);
    assign ack_s         = clrPend & int_pending_s;

    // Lowest index wins: scan downwards so the last hit is the smallest active bit.
    always_comb begin
        win_idx_s    = {VEC_W{1'b0}};
        win_onehot_s = {NUM_IRQ{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active_s[i]) begin
                win_idx_s    = VEC_W'(i);
                win_onehot_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << i;
            end else begin
                win_idx_s    = win_idx_s;
                win_onehot_s = win_onehot_s;
            end
        end
    end

    // Next-state for pending, mask, enable, FSM and vector.
    always_comb begin
        state_d   = state_q;
        vector_d  = vector_q;
        mask_d    = mask_q;
        glob_en_d = glob_en_q;
`ifdef INT_LEVEL_SENSE_EN
        pending_d = s1_q;
`else
        // New rises are ORed in after the ack clear so a coincident rise is never lost.
        pending_d = (pending_q & ~(ack_s ? win_onehot_s : {NUM_IRQ{1'b0}})) | rise_s;
`endif
        if (MASKclr) begin
            mask_d = {NUM_IRQ{1'b0}};
        end else if (MASKld) begin
            mask_d = maskIn;
        end else begin
            mask_d = mask_q;
        end
        if (INTclr || intDisable) begin
            glob_en_d = 1'b0;
        end else if (INTld) begin
            glob_en_d = 1'b1;
        end else begin
            glob_en_d = glob_en_q;
        end
        case (state_q)
            IDLE: begin
                if (ack_s) begin
                    state_d  = SERVICE;
                    vector_d = win_idx_s;
                end else begin
                    state_d  = IDLE;
                end
            end
            SERVICE: begin
                if (intReturn) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q      <= {NUM_IRQ{1'b0}};
            s1_q      <= {NUM_IRQ{1'b0}};
            pending_q <= {NUM_IRQ{1'b0}};
            mask_q    <= {NUM_IRQ{1'b0}};
            glob_en_q <= 1'b0;
            state_q   <= IDLE;
            vector_q  <= {VEC_W{1'b0}};
        end else begin
            s0_q      <= irq;
            s1_q      <= s0_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            glob_en_q <= glob_en_d;
            state_q   <= state_d;
            vector_q  <= vector_d;
        end
    end

`ifndef INT_LEVEL_SENSE_EN
    // Edge history for rise detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= {NUM_IRQ{1'b0}};
        end else begin
            prev_q <= s1_q;
        end
    end
`endif

    assign intPending = int_pending_s;
    assign intVector  = vector_q;
    assign inService  = (state_q == SERVICE);
    assign pendStatus = pending_q;

endmodule
